// File: rtl/fb_pkg.sv
// Shared framebuffer geometry and arbiter state encoding for the 90x90x2-bit
// pixel store; also used by the renderer and the host loader.
package fb_pkg;

    localparam int FB_W     = 90;
    localparam int FB_H     = 90;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int FB_AW    = 13;
    localparam int FB_DW    = 2;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } fb_state_t;

endpackage : fb_pkg

// File: rtl/fb_access_arbiter.sv
// Single-port framebuffer arbiter: video reads always win, the clear-screen
// sequencer takes free cycles next, and host writes get whatever is left.
module fb_access_arbiter
    import fb_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH,
    parameter int AW    = FB_AW,
    parameter int DW    = FB_DW
) (
    input  logic          I_pxl_clk,
    input  logic          I_rst_n,
    input  logic          I_rd_en,
    input  logic [AW-1:0] I_rd_addr,
    output logic [DW-1:0] O_rd_data,
    input  logic          I_wr_valid,
    output logic          O_wr_ready,
    input  logic [AW-1:0] I_wr_addr,
    input  logic [DW-1:0] I_wr_data,
    output logic          O_wr_oor,
    input  logic          I_clr_req,
    input  logic [DW-1:0] I_clr_colour,
    output logic          O_clr_busy,
    output logic          O_clr_done,
    output logic [AW-1:0] O_ram_addr,
    output logic          O_ram_we,
    output logic [DW-1:0] O_ram_wdata,
    input  logic [DW-1:0] I_ram_rdata
);

    // One extra bit so a full-width host address can be compared against DEPTH.
    localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    fb_state_t     r_state;
    logic [AW-1:0] r_clr_cnt;
    logic [DW-1:0] r_clr_colour;
    logic [AW-1:0] r_ram_addr;
    logic          r_ram_we;
    logic [DW-1:0] r_ram_wdata;
    logic          r_wr_oor;
    logic          r_clr_done;

    fb_state_t     w_next_state;
    logic [AW-1:0] w_next_cnt;
    logic [DW-1:0] w_next_colour;
    logic [AW-1:0] w_next_addr;
    logic          w_next_we;
    logic [DW-1:0] w_next_wdata;
    logic          w_next_oor;
    logic          w_next_done;
    logic          w_wr_ready;
    logic          w_wr_fire;
    logic          w_wr_in_range;

    assign w_wr_ready    = (r_state == S_IDLE) & ~I_rd_en & ~I_clr_req;
    assign w_wr_fire     = I_wr_valid & w_wr_ready;
    assign w_wr_in_range = {1'b0, I_wr_addr} < DEPTH_EXT;

    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_clr_cnt;
        w_next_colour = r_clr_colour;
        w_next_addr   = r_ram_addr;
        w_next_we     = 1'b0;
        w_next_wdata  = r_ram_wdata;
        w_next_oor    = 1'b0;
        w_next_done   = 1'b0;

        if (I_rd_en) begin
            w_next_addr = I_rd_addr;
        end

        unique case (r_state)
            S_IDLE: begin
                if (I_clr_req) begin
                    w_next_state  = S_CLEAR;
                    w_next_cnt    = '0;
                    w_next_colour = I_clr_colour;
                end else if (w_wr_fire) begin
                    // Out-of-range writes still complete the handshake but never reach the RAM.
                    if (w_wr_in_range) begin
                        w_next_we    = 1'b1;
                        w_next_addr  = I_wr_addr;
                        w_next_wdata = I_wr_data;
                    end else begin
                        w_next_oor   = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                if (!I_rd_en) begin
                    w_next_we    = 1'b1;
                    w_next_addr  = r_clr_cnt;
                    w_next_wdata = r_clr_colour;
                    if (r_clr_cnt == LAST_ADDR) begin
                        w_next_state = S_IDLE;
                        w_next_cnt   = '0;
                        w_next_done  = 1'b1;
                    end else begin
                        w_next_cnt   = r_clr_cnt + AW'(1);
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state      <= S_IDLE;
            r_clr_cnt    <= '0;
            r_clr_colour <= '0;
            r_ram_addr   <= '0;
            r_ram_we     <= 1'b0;
            r_ram_wdata  <= '0;
            r_wr_oor     <= 1'b0;
            r_clr_done   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_clr_cnt    <= w_next_cnt;
            r_clr_colour <= w_next_colour;
            r_ram_addr   <= w_next_addr;
            r_ram_we     <= w_next_we;
            r_ram_wdata  <= w_next_wdata;
            r_wr_oor     <= w_next_oor;
            r_clr_done   <= w_next_done;
        end
    end

    // Busy drops on the same cycle the final clear write is presented to the RAM.
    assign O_clr_busy  = (r_state == S_CLEAR);
    assign O_clr_done  = r_clr_done;
    assign O_wr_ready  = w_wr_ready;
    assign O_wr_oor    = r_wr_oor;
    assign O_ram_addr  = r_ram_addr;
    assign O_ram_we    = r_ram_we;
    assign O_ram_wdata = r_ram_wdata;
    assign O_rd_data   = I_ram_rdata;

endmodule : fb_access_arbiter

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter with a behavioural 1-cycle synchronous RAM
// attached to the registered RAM port.
module tb_fb_access_arbiter;
    import fb_pkg::*;

    logic        clk = 1'b0;
    logic        rstN;
    logic        rdEn;
    logic [12:0] rdAddr;
    logic [1:0]  rdData;
    logic        wrValid;
    logic        wrReady;
    logic [12:0] wrAddr;
    logic [1:0]  wrData;
    logic        wrOor;
    logic        clrReq;
    logic [1:0]  clrColour;
    logic        clrBusy;
    logic        clrDone;
    logic [12:0] ramAddr;
    logic        ramWe;
    logic [1:0]  ramWdata;
    logic [1:0]  ramRdata;

    logic [1:0]  mem [0:8191];

    integer checks = 0;
    integer errors = 0;

    always #5 clk = ~clk;

    fb_access_arbiter dut (
        .I_pxl_clk    (clk),
        .I_rst_n      (rstN),
        .I_rd_en      (rdEn),
        .I_rd_addr    (rdAddr),
        .O_rd_data    (rdData),
        .I_wr_valid   (wrValid),
        .O_wr_ready   (wrReady),
        .I_wr_addr    (wrAddr),
        .I_wr_data    (wrData),
        .O_wr_oor     (wrOor),
        .I_clr_req    (clrReq),
        .I_clr_colour (clrColour),
        .O_clr_busy   (clrBusy),
        .O_clr_done   (clrDone),
        .O_ram_addr   (ramAddr),
        .O_ram_we     (ramWe),
        .O_ram_wdata  (ramWdata),
        .I_ram_rdata  (ramRdata)
    );

    // Behavioural framebuffer RAM: read data appears one clock after the address.
    always @(posedge clk) begin
        if (ramWe) mem[ramAddr] <= ramWdata;
        ramRdata <= mem[ramAddr];
    end

    // Runs one clear with video reads toggling every cycle and gathers statistics.
    task automatic runClear(input logic [1:0] colour, input int stopAt, input int secondAt,
                            input bit withHost, output int writes, output int bad,
                            output int dones, output int readyBad, output bit readyAtReq,
                            output bit timedOut);
        int          expAddr;
        bit          prevRd;
        logic [12:0] prevAddr;
        bit          doneSeen;
        bit          secondDone;
        bit          finished;
        writes = 0; bad = 0; dones = 0; readyBad = 0;
        expAddr = 0; prevRd = 1'b0; prevAddr = '0;
        doneSeen = 1'b0; secondDone = 1'b0; finished = 1'b0; timedOut = 1'b0;
        @(negedge clk);
        rdEn = 1'b0;
        clrReq = 1'b1;
        clrColour = colour;
        if (withHost) begin
            wrValid = 1'b1;
            wrAddr  = 13'd20;
            wrData  = 2'b11;
        end
        #1 readyAtReq = wrReady;
        for (int i = 0; i < 20000 && !finished; i++) begin
            @(negedge clk);
            if (doneSeen) begin
                if (clrDone) dones++;
                finished = 1'b1;
            end else begin
                if (ramWe) begin
                    writes++;
                    if (prevRd || ramAddr !== 13'(expAddr) || ramWdata !== colour) bad++;
                    expAddr++;
                end else if (prevRd && ramAddr !== prevAddr) begin
                    bad++;
                end
                if (clrBusy && wrReady) readyBad++;
                if (clrDone) begin
                    dones++;
                    doneSeen = 1'b1;
                    if (clrBusy || !ramWe || ramAddr !== 13'(FB_DEPTH - 1)) bad++;
                end else if (!clrBusy) begin
                    bad++;
                end
                if (stopAt >= 0 && writes == stopAt) finished = 1'b1;
            end
            if (!finished) begin
                clrReq = 1'b0;
                if (secondAt >= 0 && writes == secondAt && !secondDone) begin
                    clrReq = 1'b1;
                    clrColour = 2'b10;
                    secondDone = 1'b1;
                end
                rdEn = (i % 2) == 1;
                rdAddr = 13'($urandom_range(0, 8191));
                prevRd = rdEn;
                prevAddr = rdAddr;
            end
        end
        if (!finished) timedOut = 1'b1;
        rdEn = 1'b0;
        clrReq = 1'b0;
    endtask

    task automatic test_reset;
        rstN = 1'b0;
        rdEn = 1'b0; rdAddr = '0;
        wrValid = 1'b0; wrAddr = '0; wrData = '0;
        clrReq = 1'b0; clrColour = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (ramAddr !== 13'd0 || ramWe !== 1'b0 || ramWdata !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_ram addr=%0d we=%b wdata=%b required 0/0/00", ramAddr, ramWe, ramWdata);
        end
        checks++;
        if (clrBusy !== 1'b0 || clrDone !== 1'b0 || wrOor !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags busy=%b done=%b oor=%b required 0/0/0", clrBusy, clrDone, wrOor);
        end
        checks++;
        if (wrReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready got=%b required 1", wrReady);
        end
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_video_read;
        @(negedge clk);
        rdEn = 1'b1;
        rdAddr = 13'd100;
        #1;
        checks++;
        if (wrReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL video_ready got=%b required 0", wrReady);
        end
        @(negedge clk);
        checks++;
        if (ramAddr !== 13'd100 || ramWe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL video_addr addr=%0d we=%b required 100/0", ramAddr, ramWe);
        end
        @(negedge clk);
        checks++;
        if (rdData !== 2'b11) begin
            errors++;
            $display("[TB] FAIL video_data got=%b required 11", rdData);
        end
        rdEn = 1'b0;
    endtask

    task automatic test_host_write;
        @(negedge clk);
        wrValid = 1'b1; wrAddr = 13'd45; wrData = 2'b10;
        #1;
        checks++;
        if (wrReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_ready got=%b required 1", wrReady);
        end
        @(negedge clk);
        wrValid = 1'b0;
        checks++;
        if (ramWe !== 1'b1 || ramAddr !== 13'd45 || ramWdata !== 2'b10) begin
            errors++;
            $display("[TB] FAIL write_issue we=%b addr=%0d wdata=%b required 1/45/10", ramWe, ramAddr, ramWdata);
        end
        @(negedge clk);
        checks++;
        if (ramWe !== 1'b0 || ramAddr !== 13'd45) begin
            errors++;
            $display("[TB] FAIL write_hold we=%b addr=%0d required 0/45", ramWe, ramAddr);
        end
        // Host write blocked by video for two cycles, then lands.
        rdEn = 1'b1; rdAddr = 13'd7;
        wrValid = 1'b1; wrAddr = 13'd46; wrData = 2'b01;
        #1;
        checks++;
        if (wrReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_blocked_ready got=%b required 0", wrReady);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ramWe !== 1'b0 || ramAddr !== 13'd7) begin
            errors++;
            $display("[TB] FAIL write_blocked we=%b addr=%0d required 0/7", ramWe, ramAddr);
        end
        rdEn = 1'b0;
        #1;
        checks++;
        if (wrReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_unblocked_ready got=%b required 1", wrReady);
        end
        @(negedge clk);
        wrValid = 1'b0;
        checks++;
        if (ramWe !== 1'b1 || ramAddr !== 13'd46 || ramWdata !== 2'b01) begin
            errors++;
            $display("[TB] FAIL write_after_video we=%b addr=%0d wdata=%b required 1/46/01", ramWe, ramAddr, ramWdata);
        end
    endtask

    task automatic test_out_of_range;
        @(negedge clk);
        wrValid = 1'b1; wrAddr = 13'd8100; wrData = 2'b11;
        #1;
        checks++;
        if (wrReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL oor_ready got=%b required 1", wrReady);
        end
        @(negedge clk);
        wrValid = 1'b0;
        checks++;
        if (ramWe !== 1'b0 || wrOor !== 1'b1 || ramAddr !== 13'd46) begin
            errors++;
            $display("[TB] FAIL oor_pulse we=%b oor=%b addr=%0d required 0/1/46", ramWe, wrOor, ramAddr);
        end
        @(negedge clk);
        checks++;
        if (wrOor !== 1'b0) begin
            errors++;
            $display("[TB] FAIL oor_single got=%b required 0", wrOor);
        end
    endtask

    task automatic test_clear;
        int writes, bad, dones, readyBad;
        bit readyAtReq, timedOut;
        runClear(2'b01, -1, -1, 1'b0, writes, bad, dones, readyBad, readyAtReq, timedOut);
        checks++;
        if (timedOut !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_timeout got=%b required 0", timedOut);
        end
        checks++;
        if (writes != 8100 || bad != 0) begin
            errors++;
            $display("[TB] FAIL clear_writes count=%0d bad=%0d required 8100/0", writes, bad);
        end
        checks++;
        if (dones != 1 || readyBad != 0 || readyAtReq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_flags dones=%0d readyBad=%0d readyAtReq=%b required 1/0/0", dones, readyBad, readyAtReq);
        end
        checks++;
        if (mem[8099] !== 2'b01 || mem[45] !== 2'b01) begin
            errors++;
            $display("[TB] FAIL clear_mem m8099=%b m45=%b required 01/01", mem[8099], mem[45]);
        end
    endtask

    task automatic test_clear_with_write;
        int writes, bad, dones, readyBad;
        bit readyAtReq, timedOut;
        runClear(2'b00, -1, 500, 1'b1, writes, bad, dones, readyBad, readyAtReq, timedOut);
        checks++;
        if (readyAtReq !== 1'b0 || readyBad != 0) begin
            errors++;
            $display("[TB] FAIL clrwr_ready readyAtReq=%b readyBad=%0d required 0/0", readyAtReq, readyBad);
        end
        checks++;
        if (timedOut !== 1'b0 || writes != 8100 || bad != 0 || dones != 1) begin
            errors++;
            $display("[TB] FAIL clrwr_clear to=%b writes=%0d bad=%0d dones=%0d required 0/8100/0/1", timedOut, writes, bad, dones);
        end
        repeat (3) @(negedge clk);
        wrValid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem[20] !== 2'b11 || mem[21] !== 2'b00) begin
            errors++;
            $display("[TB] FAIL clrwr_host m20=%b m21=%b required 11/00", mem[20], mem[21]);
        end
    endtask

    task automatic test_reset_mid_clear;
        int writes, bad, dones, readyBad;
        bit readyAtReq, timedOut;
        runClear(2'b10, 3000, -1, 1'b0, writes, bad, dones, readyBad, readyAtReq, timedOut);
        checks++;
        if (writes != 3000 || bad != 0) begin
            errors++;
            $display("[TB] FAIL partial_clear writes=%0d bad=%0d required 3000/0", writes, bad);
        end
        rstN = 1'b0;
        #1;
        checks++;
        if (clrBusy !== 1'b0 || ramWe !== 1'b0 || ramAddr !== 13'd0) begin
            errors++;
            $display("[TB] FAIL async_reset busy=%b we=%b addr=%0d required 0/0/0", clrBusy, ramWe, ramAddr);
        end
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checks++;
        if (clrBusy !== 1'b0 || ramWe !== 1'b0 || mem[100] !== 2'b10 || mem[5000] !== 2'b00) begin
            errors++;
            $display("[TB] FAIL after_reset busy=%b we=%b m100=%b m5000=%b required 0/0/10/00", clrBusy, ramWe, mem[100], mem[5000]);
        end
        runClear(2'b01, -1, -1, 1'b0, writes, bad, dones, readyBad, readyAtReq, timedOut);
        checks++;
        if (timedOut !== 1'b0 || writes != 8100 || bad != 0 || dones != 1) begin
            errors++;
            $display("[TB] FAIL restart_clear to=%b writes=%0d bad=%0d dones=%0d required 0/8100/0/1", timedOut, writes, bad, dones);
        end
        checks++;
        if (mem[0] !== 2'b01 || mem[5000] !== 2'b01) begin
            errors++;
            $display("[TB] FAIL restart_mem m0=%b m5000=%b required 01/01", mem[0], mem[5000]);
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 2'b00;
        mem[100] = 2'b11;
        test_reset();
        test_video_read();
        test_host_write();
        test_out_of_range();
        test_clear();
        test_clear_with_write();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fb_access_arbiter

// File: doc/fb_access_arbiter.md
Name: fb_access_arbiter

Overview:
- Shares the single-port 90x90x2-bit pixel framebuffer RAM between three requesters: the video read path (pixel_address/pixel_colour of the HDMI renderer), a host write port (UART/SPI loader) and an internal clear-screen sequencer.
- Video reads have absolute priority. Host writes and clear fill only use cycles where the renderer does not need the RAM.
- Sits between the renderer, the host loader and the framebuffer BRAM in the HDMI top level.

Parameters:
- DEPTH, 8100, number of pixels in framebuffer (90x90)
- AW, 13, address width
- DW, 2, pixel data width (palette index)

Ports:
- I_pxl_clk  input  1  pixel clock
- I_rst_n  input  1  asynchronous active-low reset
- I_rd_en  input  1  renderer needs RAM this cycle (its active-video read window)
- I_rd_addr  input  AW  renderer read address
- O_rd_data  output  DW  read data to renderer, equal to I_ram_rdata
- I_wr_valid  input  1  host write request
- O_wr_ready  output  1  host write accepted this cycle
- I_wr_addr  input  AW  host write address
- I_wr_data  input  DW  host write pixel
- O_wr_oor  output  1  one-cycle pulse: accepted write had address >= DEPTH, dropped
- I_clr_req  input  1  start clear-screen (single-cycle pulse or level)
- I_clr_colour  input  DW  fill value, latched on request
- O_clr_busy  output  1  clear in progress
- O_clr_done  output  1  one-cycle pulse when clear completes
- O_ram_addr  output  AW  registered RAM address
- O_ram_we  output  1  registered RAM write enable
- O_ram_wdata  output  DW  registered RAM write data
- I_ram_rdata  input  DW  RAM read data, 1-cycle synchronous RAM

Behaviour:
- Reset (async, I_rst_n=0):
  - State is S_IDLE.
  - O_ram_addr=0, O_ram_we=0, O_ram_wdata=0, O_clr_busy=0, O_clr_done=0, O_wr_oor=0.
  - Clear address counter is 0.
- RAM outputs are registered, so each grant appears on O_ram_* one cycle later.
- Video read latency: I_rd_addr at cycle t -> O_ram_addr at t+1 -> O_rd_data valid at t+2. The renderer accounts for 2 cycles.
- Priority per cycle: video (I_rd_en=1) > clear sequencer (S_CLEAR) > host write.
  - Whenever I_rd_en=1, the next-cycle O_ram_we is 0 and O_ram_addr is I_rd_addr.
  - When no requester is granted, O_ram_addr holds its value and O_ram_we=0.
- O_wr_ready is combinational: (state==S_IDLE) & !I_rd_en & !I_clr_req.
  - A transfer occurs at a rising edge with I_wr_valid & O_wr_ready.
  - Next cycle: O_ram_we=1, O_ram_addr=I_wr_addr, O_ram_wdata=I_wr_data.
  - Host must hold valid/addr/data until the transfer; there is no buffering.
- Out-of-range write (I_wr_addr >= DEPTH):
  - Still accepted (ready handshake completes).
  - Next cycle: O_ram_we=0 and O_wr_oor=1 for one cycle.
- FSM states: S_IDLE, S_CLEAR.
  - S_IDLE -> S_CLEAR on I_clr_req=1: latch I_clr_colour, clear counter=0, O_clr_busy=1 from next cycle.
  - In S_CLEAR, on each cycle with I_rd_en=0: next cycle O_ram_we=1, O_ram_addr=counter, O_ram_wdata=latched colour; counter increments.
  - In S_CLEAR, cycles with I_rd_en=1 stall the counter.
  - When counter==DEPTH-1 is issued: return to S_IDLE. O_clr_busy falls and O_clr_done pulses 1 in the same cycle that the final write is on O_ram_*.
- Simultaneous I_clr_req and I_wr_valid in S_IDLE: clear wins, write is not accepted (ready=0).
- I_clr_req while in S_CLEAR is ignored; there is no restart, and the colour is not re-latched.
- Clear during active video: progresses only in blanking cycles. Full clear takes DEPTH free cycles, well within one frame's blanking at 720p.
- Reset mid-clear: immediate return to S_IDLE with busy=0. Memory is left partially filled and there is no resume.
- Counter width AW. Comparison against DEPTH-1 is exact, with no wrap beyond DEPTH.

Decomposition:
- Shared package fb_pkg:
  - FB_W=90, FB_H=90, FB_DEPTH=8100, FB_AW=13, FB_DW=2
  - state encoding S_IDLE=1'b0, S_CLEAR=1'b1
- Also used by the renderer and the host loader.
- No sub-module; the clear counter and arbiter mux live in one module.

Test Plan:
- Reset then I_rd_en=1, I_rd_addr=13'd100 -> O_ram_addr=100 after 1 clk, O_ram_we=0; RAM preloaded 2'b11 at 100 gives O_rd_data=2'b11 at t+2.
- I_rd_en=0, host writes addr 45 data 2'b10 -> O_wr_ready=1 and next cycle O_ram_we=1, O_ram_addr=45, O_ram_wdata=2'b10. Repeat with I_rd_en=1 -> O_wr_ready=0, no write until I_rd_en falls.
- Host write addr 8100 -> handshake completes, O_ram_we stays 0, O_wr_oor pulses once.
- I_clr_req with colour 2'b01 and I_rd_en toggling 50% -> exactly 8100 writes of 2'b01 to addresses 0..8099 in order, none while I_rd_en=1; O_clr_done single pulse; O_wr_ready=0 throughout busy.
- I_clr_req and I_wr_valid in the same cycle -> clear starts, write not accepted until O_clr_busy=0. Second I_clr_req at counter 500 -> ignored, total writes still 8100.
- Assert I_rst_n=0 at clear counter 3000 -> O_clr_busy=0, O_ram_we=0 asynchronously; after release, a new clear restarts at address 0.
